// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - central stall/freeze controller for the 5-stage pipeline
//
// Purpose: drives the freeze inputs of the IF/ID, ID/EXE, EXE/MEM and MEM/WB
// pipeline registers and the NOP bubble into ID/EXE. It sequences data-cache
// miss waits, load-use hazards and the drain that follows a halt.
//
// Ports:
//   clk          clock
//   rst_b        asynchronous active-low reset
//   mem_req      MEM stage holds a load/store this cycle
//   mem_ready    cache reports hit or fill-complete this cycle
//   load_use     ID instruction depends on the load currently in EXE
//   halt_in      EXE/MEM halted flag
//   freeze_if    freeze PC and IF/ID
//   freeze_id    freeze ID/EXE
//   freeze_exe   freeze EXE/MEM
//   freeze_mem   freeze MEM/WB
//   bubble_ex    load ID/EXE with a NOP this edge
//   halted       core halted (sticky)
//   mem_error    cache timeout (sticky)
//   stall_count  saturating count of cycles with freeze_mem=1, outside HALT
//   state_o      current state (RUN=0, MEM_WAIT=1, DRAIN=2, HALT=3)

module pipe_stall_ctrl #(
    parameter int MISS_TIMEOUT = 64,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             load_use,
    input  logic             halt_in,
    output logic             freeze_if,
    output logic             freeze_id,
    output logic             freeze_exe,
    output logic             freeze_mem,
    output logic             bubble_ex,
    output logic             halted,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       state_o
);

    localparam int WW = $clog2(MISS_TIMEOUT + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [WW-1:0] TIMEOUT_V = WW'(MISS_TIMEOUT);
    localparam logic [DW-1:0] DRAIN_V   = DW'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [WW-1:0] wait_cnt, wait_nx;
    logic [DW-1:0] drain_cnt, drain_nx;
    logic          halted_nx, mem_error_nx;
    logic          frz_front, frz_back, bubble;
    logic          miss;

    // mem_req dropping during a wait also clears miss, so it ends the wait
    // exactly like mem_ready would.
    assign miss = mem_req & ~mem_ready;

    always_comb begin
        state_nx     = state;
        wait_nx      = wait_cnt;
        drain_nx     = drain_cnt;
        halted_nx    = halted;
        mem_error_nx = mem_error;
        frz_front    = 1'b0;
        frz_back     = 1'b0;
        bubble       = 1'b0;

        case (state)
            ST_RUN, ST_MEM_WAIT: begin
                if (miss) begin
                    frz_front = 1'b1;
                    frz_back  = 1'b1;
                    if (state == ST_RUN) begin
                        state_nx = ST_MEM_WAIT;
                        wait_nx  = WW'(1);
                    end else if (wait_cnt == TIMEOUT_V) begin
                        mem_error_nx = 1'b1;
                        state_nx     = ST_HALT;
                    end else begin
                        wait_nx = wait_cnt + WW'(1);
                    end
                end else begin
                    // The cycle the cache answers is an ordinary RUN cycle.
                    state_nx = ST_RUN;
                    wait_nx  = '0;
                    if (halt_in) begin
                        frz_front = 1'b1;
                        bubble    = 1'b1;
                        state_nx  = ST_DRAIN;
                        drain_nx  = DW'(1);
                    end else if (load_use) begin
                        frz_front = 1'b1;
                        bubble    = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (miss) begin
                    // Older instructions still in MEM must complete before
                    // the drain can make progress; the count pauses.
                    frz_front = 1'b1;
                    frz_back  = 1'b1;
                end else begin
                    frz_front = 1'b1;
                    bubble    = 1'b1;
                    if (drain_cnt == DRAIN_V) begin
                        state_nx  = ST_HALT;
                        halted_nx = 1'b1;
                    end else begin
                        drain_nx = drain_cnt + DW'(1);
                    end
                end
            end
            default: begin
                frz_front = 1'b1;
                frz_back  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            halted    <= 1'b0;
            mem_error <= 1'b0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_nx;
            drain_cnt <= drain_nx;
            halted    <= halted_nx;
            mem_error <= mem_error_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stall_count <= '0;
        end else if (frz_back && (state != ST_HALT) && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    // Gated by reset so the pipeline registers see no freeze while held.
    assign freeze_if  = rst_b & frz_front;
    assign freeze_id  = rst_b & frz_front;
    assign freeze_exe = rst_b & frz_back;
    assign freeze_mem = rst_b & frz_back;
    assign bubble_ex  = rst_b & bubble;
    assign state_o    = state;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - self-checking bench for pipe_stall_ctrl

module tb_pipe_stall_ctrl;

    localparam int TO    = 4;
    localparam int DR    = 2;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          mem_req = 1'b0;
    logic          mem_ready = 1'b0;
    logic          load_use = 1'b0;
    logic          halt_in = 1'b0;
    logic          freeze_if, freeze_id, freeze_exe, freeze_mem, bubble_ex;
    logic          halted, mem_error;
    logic [CW-1:0] stall_count;
    logic [1:0]    state_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode 0 run, 1 waiting on cache, 2 draining, 3 halted.
    int m_mode, m_wait, m_drain, m_cnt;
    bit m_h, m_e;

    pipe_stall_ctrl #(.MISS_TIMEOUT(TO), .DRAIN_CYCLES(DR), .CNT_W(CW)) dut (
        .clk(clk), .rst_b(rst_b),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .load_use(load_use), .halt_in(halt_in),
        .freeze_if(freeze_if), .freeze_id(freeze_id),
        .freeze_exe(freeze_exe), .freeze_mem(freeze_mem),
        .bubble_ex(bubble_ex), .halted(halted), .mem_error(mem_error),
        .stall_count(stall_count), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_drain = 0; m_cnt = 0; m_h = 0; m_e = 0;
    endtask

    // One cycle: drive inputs, check combinational and registered outputs
    // mid-cycle against the model, then advance both on the clock edge.
    task automatic step(input bit req, input bit rdy, input bit lu, input bit hi);
        bit miss, fa, fb, bb, n_h, n_e;
        int n_mode, n_wait, n_drain;
        logic [8:0] exp_v, obs_v;
        mem_req = req; mem_ready = rdy; load_use = lu; halt_in = hi;
        #4;
        miss = req && !rdy;
        fa = 0; fb = 0; bb = 0;
        n_mode = m_mode; n_wait = m_wait; n_drain = m_drain; n_h = m_h; n_e = m_e;
        if (m_mode == 3) begin
            fa = 1; fb = 1;
        end else if (m_mode == 2) begin
            if (miss) begin
                fa = 1; fb = 1;
            end else begin
                fa = 1; bb = 1;
                if (m_drain == DR) begin n_mode = 3; n_h = 1; end
                else n_drain = m_drain + 1;
            end
        end else if (miss) begin
            fa = 1; fb = 1;
            if (m_mode == 0) begin n_mode = 1; n_wait = 1; end
            else if (m_wait == TO) begin n_mode = 3; n_e = 1; end
            else n_wait = m_wait + 1;
        end else begin
            n_mode = 0; n_wait = 0;
            if (hi) begin fa = 1; bb = 1; n_mode = 2; n_drain = 1; end
            else if (lu) begin fa = 1; bb = 1; end
        end
        exp_v = {fa, fa, fb, fb, bb, m_h, m_e, 2'(m_mode)};
        obs_v = {freeze_if, freeze_id, freeze_exe, freeze_mem, bubble_ex,
                 halted, mem_error, state_o};
        n_cmp++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL outputs t=%0t got %b want %b (if id exe mem bub halt err st)",
                     $time, obs_v, exp_v);
        end
        n_cmp++;
        if (stall_count !== CW'(m_cnt)) begin
            n_err++;
            $display("FAIL stall_count t=%0t got %0d want %0d", $time, stall_count, m_cnt);
        end
        @(posedge clk);
        if (fb && m_mode != 3 && m_cnt < CMAX) m_cnt++;
        m_mode = n_mode; m_wait = n_wait; m_drain = n_drain; m_h = n_h; m_e = n_e;
        #1;
    endtask

    task automatic check_val(input string name, input int obs, input int exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s t=%0t got %0d want %0d", name, $time, obs, exp_v);
        end
    endtask

    // Assert reset asynchronously with a miss on the inputs and verify that
    // everything drops to zero before any clock edge.
    task automatic apply_reset();
        mem_req = 1'b1; mem_ready = 1'b0; load_use = 1'b1; halt_in = 1'b1;
        rst_b = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({freeze_if, freeze_id, freeze_exe, freeze_mem, bubble_ex, halted,
             mem_error, state_o, stall_count} !== '0) begin
            n_err++;
            $display("FAIL async_reset t=%0t got fr=%b%b%b%b bub=%b h=%b e=%b st=%0d cnt=%0d want all 0",
                     $time, freeze_if, freeze_id, freeze_exe, freeze_mem, bubble_ex,
                     halted, mem_error, state_o, stall_count);
        end
        @(posedge clk);
        mem_req = 1'b0; mem_ready = 1'b0; load_use = 1'b0; halt_in = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        check_val("idle_state", int'(state_o), 0);
        check_val("idle_count", int'(stall_count), 0);
    endtask

    task automatic test_miss();
        apply_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        check_val("miss_wait_state", int'(state_o), 1);
        step(1, 1, 0, 0);
        check_val("miss_count", int'(stall_count), 3);
        check_val("miss_back_run", int'(state_o), 0);
        step(0, 0, 0, 0);
    endtask

    task automatic test_load_use();
        apply_reset();
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check_val("lu_count", int'(stall_count), 0);
        // load_use honoured on the cycle the cache answers
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic test_halt();
        apply_reset();
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check_val("halt_flag", int'(halted), 1);
        check_val("halt_state", int'(state_o), 3);
        for (int i = 0; i < 4; i++) step(1, i[0], 1, 0);
        check_val("halt_count", int'(stall_count), 0);
        // miss mid-drain pauses the drain
        apply_reset();
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check_val("drain_paused", int'(state_o), 2);
        step(0, 0, 0, 0);
        check_val("drain_done", int'(halted), 1);
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int i = 0; i < 1 + TO; i++) step(1, 0, 0, 0);
        check_val("to_error", int'(mem_error), 1);
        check_val("to_halted", int'(halted), 0);
        check_val("to_state", int'(state_o), 3);
        check_val("to_count", int'(stall_count), 1 + TO);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1);
        check_val("to_count_hold", int'(stall_count), 1 + TO);
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        apply_reset();
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        check_val("post_reset_count", int'(stall_count), 1);
        step(0, 0, 0, 1);
        apply_reset();
        step(0, 0, 0, 0);
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < 100; i++) begin
            for (int j = 0; j < 3; j++) step(1, 0, 0, 0);
            step(1, 1, 0, 0);
        end
        check_val("sat_count", int'(stall_count), CMAX);
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) apply_reset();
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 29) == 0));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_miss();
        test_load_use();
        test_halt();
        test_timeout();
        test_reset_mid_wait();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
